// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI FIFO-mode grant engine.
package pci_arb_pkg;

  localparam int MAX_DEV   = 32;
  localparam int MAX_IDX_W = $clog2(MAX_DEV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Active-low one-hot; an index that is X or >= n leaves every line deasserted.
  function automatic logic [MAX_DEV-1:0] onehot_n(input logic [MAX_IDX_W-1:0] idx, input int n);
    logic [MAX_DEV-1:0] v;
    v = '1;
    if (!$isunknown(idx) && (int'(idx) < n)) v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/pci_arb_idx_fifo.sv
// Circular queue of device indices; 1-cycle push-to-head; a push into a full queue is accepted only alongside a pop.
module pci_arb_idx_fifo #(
  parameter int IDX_W = 3,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [IDX_W-1:0] din,
  output logic [IDX_W-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Explicit wrap keeps non-power-of-two depths correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pci_fifo_grant_queue.sv
// FCFS PCI grant engine: new REQ# assertions queued in arrival order, head gets a registered one-hot GNT#, 3 edges from idle.
// A full queue holds requests pending; PCI_ARB_PARK_EN parks GNT# on PARK_DEV while idle with an empty queue.
module pci_fifo_grant_queue
  import pci_arb_pkg::*;
#(
  parameter int N_DEV    = 8,
  parameter int DEPTH    = 8,
  parameter int PARK_DEV = 0,
  localparam int IDX_W   = $clog2(N_DEV),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] req_n,
  input  logic             rel_i,
  output logic [N_DEV-1:0] gnt_n,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [CNT_W-1:0] q_count,
  output logic             q_full
);

`ifdef PCI_ARB_PARK_EN
  localparam bit PARK_EN = 1'b1;
`else
  localparam bit PARK_EN = 1'b0;
`endif

  arb_state_t       state, state_nxt;
  logic [N_DEV-1:0] req_prev, pending, queued;
  logic [N_DEV-1:0] new_req, withdraw, enq_vec, pop_vec;
  logic [N_DEV-1:0] grant_vec, park_vec, gnt_n_nxt;
  logic [IDX_W-1:0] enq_idx, head, idx_nxt;
  logic             enq_any, push, pop, q_empty, q_empty_nxt, park_now, valid_nxt;

  pci_arb_idx_fifo #(.IDX_W(IDX_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (enq_idx),
    .head  (head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign new_req  = ~req_n & req_prev & ~pending & ~queued;
  assign withdraw = pending & req_n;

  always_comb begin
    enq_any = 1'b0;
    enq_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (pending[i]) begin
        enq_any = 1'b1;
        enq_idx = IDX_W'(i);
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign push = enq_any && (!q_full || pop);

  always_comb begin
    enq_vec = '0;
    pop_vec = '0;
    for (int i = 0; i < N_DEV; i++) begin
      enq_vec[i] = push && (enq_idx == IDX_W'(i));
      pop_vec[i] = pop && (head == IDX_W'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    grant_vec = gnt_n;
    valid_nxt = gnt_valid;
    idx_nxt   = gnt_idx;
    unique case (state)
      IDLE: begin
        grant_vec = '1;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
        if (!q_empty) begin
          if (!req_n[head]) begin
            state_nxt = GRANT;
            grant_vec = N_DEV'(onehot_n(MAX_IDX_W'(head), N_DEV));
            valid_nxt = 1'b1;
            idx_nxt   = head;
          end else begin
            pop = 1'b1;
          end
        end
      end
      GRANT: begin
        if (rel_i || req_n[gnt_idx]) begin
          state_nxt = GAP;
          pop       = 1'b1;
          grant_vec = '1;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
        end
      end
      GAP: begin
        state_nxt = IDLE;
        grant_vec = '1;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_vec = '1;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Parking follows the post-edge view: kept only if the next cycle is IDLE with nothing
  // queued, or the sole arrival is PARK_DEV itself so its grant follows without a gap.
  assign q_empty_nxt = q_empty ? !push : ((q_count == CNT_W'(1)) && pop && !push);
  assign park_vec    = PARK_EN ? N_DEV'(onehot_n(MAX_IDX_W'(PARK_DEV), N_DEV)) : '1;
  assign park_now    = (state_nxt == IDLE) &&
                       (q_empty_nxt || (q_empty && push && (enq_idx == IDX_W'(PARK_DEV))));
  assign gnt_n_nxt   = park_now ? park_vec : grant_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_n     <= '1;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      req_prev  <= '1;
      pending   <= '0;
      queued    <= '0;
    end else begin
      state     <= state_nxt;
      gnt_n     <= gnt_n_nxt;
      gnt_valid <= valid_nxt;
      gnt_idx   <= idx_nxt;
      req_prev  <= req_n;
      pending   <= (pending | new_req) & ~withdraw & ~enq_vec;
      queued    <= (queued & ~pop_vec) | enq_vec;
    end
  end

endmodule

// File: tb/tb_pci_fifo_grant_queue.sv
// Bench for pci_fifo_grant_queue: a DEPTH=8 and a DEPTH=2 instance share stimulus; grants are scoreboarded per instance.
module tb_pci_fifo_grant_queue;

`ifdef PCI_ARB_PARK_EN
  localparam logic [7:0] IDLE_GN = 8'hFE;
`else
  localparam logic [7:0] IDLE_GN = 8'hFF;
`endif

  typedef struct {
    logic [2:0] idx;
    logic [7:0] gn;
    int         lat;
  } exp_t;

  logic       clk, rst, rel_i;
  logic [7:0] req_n;
  logic [7:0] gnt_n_a, gnt_n_b;
  logic       gv_a, gv_b, qf_a, qf_b;
  logic [2:0] gi_a, gi_b;
  logic [3:0] qc_a;
  logic [1:0] qc_b;
  logic       pv_a = 1'b0, pv_b = 1'b0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;

  pci_fifo_grant_queue #(.N_DEV(8), .DEPTH(8), .PARK_DEV(0)) u_dut (
    .clk(clk), .rst(rst), .req_n(req_n), .rel_i(rel_i), .gnt_n(gnt_n_a),
    .gnt_valid(gv_a), .gnt_idx(gi_a), .q_count(qc_a), .q_full(qf_a));

  pci_fifo_grant_queue #(.N_DEV(8), .DEPTH(2), .PARK_DEV(0)) u_small (
    .clk(clk), .rst(rst), .req_n(req_n), .rel_i(rel_i), .gnt_n(gnt_n_b),
    .gnt_valid(gv_b), .gnt_idx(gi_b), .q_count(qc_b), .q_full(qf_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input logic [2:0] idx, input int lat);
    exp_t e;
    e.idx = idx;
    e.gn = 8'hFF;
    e.gn[idx] = 1'b0;
    e.lat = lat;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  task automatic mon_grant(input int d, input logic [2:0] gi, input logic [7:0] gn);
    exp_t e;
    if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_grant dut%0d: got idx %0d expected no grant", d, gi);
      return;
    end
    if (d == 0) e = q_a.pop_front();
    else        e = q_b.pop_front();
    chk($sformatf("grant_idx dut%0d", d), 32'(gi), 32'(e.idx));
    chk($sformatf("grant_gnt_n dut%0d", d), 32'(gn), 32'(e.gn));
    if (e.lat >= 0) chk($sformatf("grant_latency dut%0d", d), 32'(cyc - t0), 32'(e.lat));
  endtask

  // Monitor: pops the scoreboard on each new grant, checks GNT# stays at most one-hot.
  always @(negedge clk) begin
    chk("onehot dut0", 32'($countones(~gnt_n_a) <= 1), 32'(1));
    chk("onehot dut1", 32'($countones(~gnt_n_b) <= 1), 32'(1));
    if (gv_a && !pv_a) mon_grant(0, gi_a, gnt_n_a);
    if (gv_b && !pv_b) mon_grant(1, gi_b, gnt_n_b);
    pv_a <= gv_a;
    pv_b <= gv_b;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_next(input string name);
    int i = 0;
    while (!gv_a && i < 40) begin
      tick(1);
      i++;
    end
    if (!gv_a) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: gnt_valid got 0 after 40 cycles, expected 1", name);
    end
    tick(2);
    rel_i = 1'b1;
    tick(1);
    rel_i = 1'b0;
  endtask

  task automatic chk_idle_out(input string name);
    chk({name, " gnt_n dut0"}, 32'(gnt_n_a), 32'(8'hFF));
    chk({name, " gnt_n dut1"}, 32'(gnt_n_b), 32'(8'hFF));
    chk({name, " gnt_valid dut0"}, 32'(gv_a), 32'(0));
    chk({name, " gnt_idx dut0"}, 32'(gi_a), 32'(0));
    chk({name, " q_count dut0"}, 32'(qc_a), 32'(0));
    chk({name, " q_count dut1"}, 32'(qc_b), 32'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, expected finish within 300us");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rel_i = 1'b0;
    req_n = 8'hFF;
    tick(2);
    chk_idle_out("reset");
    chk("reset q_full dut0", 32'(qf_a), 32'(0));
    chk("reset q_full dut1", 32'(qf_b), 32'(0));
    rst = 1'b0;
    tick(2);

    // Single request from device 2, released by rel_i.
    t0 = cyc;
    req_n = 8'hFB;
    expect_grant(3'd2, 3);
    tick(2);
    chk("single q_count after enqueue", 32'(qc_a), 32'(1));
    tick(1);
    chk("single gnt_n", 32'(gnt_n_a), 32'(8'hFB));
    tick(2);
    rel_i = 1'b1;
    tick(1);
    rel_i = 1'b0;
    chk_idle_out("single release");
    tick(1);
    chk("single gap gnt_valid", 32'(gv_a), 32'(0));
    req_n = 8'hFF;
    tick(3);

    // Arrival order 5, 1, 6.
    t0 = cyc;
    req_n = 8'hDF;
    tick(1);
    req_n = 8'hDD;
    tick(1);
    req_n = 8'h9D;
    expect_grant(3'd5, 3);
    expect_grant(3'd1, -1);
    expect_grant(3'd6, -1);
    release_next("order 5");
    release_next("order 1");
    release_next("order 6");
    req_n = 8'hFF;
    tick(4);

    // Simultaneous devices 4 and 7.
    t0 = cyc;
    req_n = 8'h6F;
    expect_grant(3'd4, 3);
    expect_grant(3'd7, -1);
    tick(2);
    chk("simul q_count dut0 first", 32'(qc_a), 32'(1));
    chk("simul q_count dut1 first", 32'(qc_b), 32'(1));
    tick(1);
    chk("simul q_count dut0 second", 32'(qc_a), 32'(2));
    chk("simul q_count dut1 second", 32'(qc_b), 32'(2));
    chk("simul q_full dut0", 32'(qf_a), 32'(0));
    chk("simul q_full dut1", 32'(qf_b), 32'(1));
    release_next("simul 4");
    release_next("simul 7");
    req_n = 8'hFF;
    tick(4);

    // Devices 0, 1, 2 into a two-entry queue.
    t0 = cyc;
    req_n = 8'hF8;
    expect_grant(3'd0, 3);
    expect_grant(3'd1, -1);
    expect_grant(3'd2, -1);
    tick(3);
    chk("full q_count dut1 two", 32'(qc_b), 32'(2));
    tick(1);
    chk("full q_count dut0 three", 32'(qc_a), 32'(3));
    chk("full q_count dut1 held", 32'(qc_b), 32'(2));
    chk("full q_full dut1", 32'(qf_b), 32'(1));
    chk("full q_full dut0", 32'(qf_a), 32'(0));
    rel_i = 1'b1;
    tick(1);
    rel_i = 1'b0;
    chk("full push+pop q_count dut1", 32'(qc_b), 32'(2));
    chk("full push+pop q_full dut1", 32'(qf_b), 32'(1));
    chk("full pop q_count dut0", 32'(qc_a), 32'(2));
    release_next("full 1");
    release_next("full 2");
    req_n = 8'hFF;
    tick(4);
    chk("full drained q_count dut1", 32'(qc_b), 32'(0));

    // Device 3 withdraws while queued behind device 0.
    t0 = cyc;
    req_n = 8'hF6;
    expect_grant(3'd0, 3);
    tick(3);
    chk("withdraw q_count", 32'(qc_a), 32'(2));
    req_n = 8'hFE;
    tick(2);
    rel_i = 1'b1;
    tick(1);
    rel_i = 1'b0;
    chk("withdraw pop q_count dut0", 32'(qc_a), 32'(1));
    tick(2);
    chk("withdraw stale pop q_count dut0", 32'(qc_a), 32'(0));
    chk("withdraw stale pop q_count dut1", 32'(qc_b), 32'(0));
    tick(3);
    chk("withdraw no grant", 32'(gv_a), 32'(0));
    req_n = 8'hFF;
    tick(2);

    // Reset in the middle of device 0's grant; held requests are recaptured.
    t0 = cyc;
    req_n = 8'hDE;
    expect_grant(3'd0, 3);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_idle_out("mid-grant reset");
    rst = 1'b0;
    t0 = cyc;
    expect_grant(3'd0, 3);
    expect_grant(3'd5, -1);
    release_next("post-reset 0");
    release_next("post-reset 5");
    req_n = 8'hFF;
    tick(4);

    // Idle-bus GNT# and the hand-over to device 4.
    chk("idle gnt_n", 32'(gnt_n_a), 32'(IDLE_GN));
    chk("idle gnt_valid", 32'(gv_a), 32'(0));
    t0 = cyc;
    req_n = 8'hEF;
    expect_grant(3'd4, 3);
    tick(1);
    chk("park pending gnt_n", 32'(gnt_n_a), 32'(IDLE_GN));
    tick(1);
    chk("park drop gnt_n", 32'(gnt_n_a), 32'(8'hFF));
    chk("park drop gnt_valid", 32'(gv_a), 32'(0));
    release_next("park 4");
    req_n = 8'hFF;
    tick(4);

    chk("scoreboard dut0 drained", 32'(q_a.size()), 32'(0));
    chk("scoreboard dut1 drained", 32'(q_b.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pci_fifo_grant_queue.md
Name: pci_fifo_grant_queue

Overview:
- Parametrised first-come-first-served grant engine for the PCI arbiter's FIFO mode.
- Detects new active-low REQ# assertions from N_DEV masters and queues the device indices in arrival order.
- Drives an active-low one-hot GNT# vector for the queue head and sequences grant hand-over with a one-cycle turnaround gap.
- Generalises the fixed 3-to-8 active-low index encoder to N_DEV masters, adding a queue, request tracking and grant sequencing.

Parameters:
- N_DEV, 8, number of bus masters (2..32).
- DEPTH, 8, queue entries (1..N_DEV). DEPTH < N_DEV is legal.
- IDX_W, $clog2(N_DEV), width of a device index; derived, not overridden.
- PARK_DEV, 0, device parked on an idle bus; used only with the optional feature.

Ports:
- clk  in  1  bus clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_n  in  N_DEV  request lines, active-low, one per master.
- rel_i  in  1  single-cycle pulse: current master's transaction is complete.
- gnt_n  out  N_DEV  grant lines, active-low, one-hot or all-ones; registered.
- gnt_valid  out  1  high while a queued grant is driven.
- gnt_idx  out  IDX_W  index of the granted device; 0 when gnt_valid is low.
- q_count  out  $clog2(DEPTH+1)  queue occupancy.
- q_full  out  1  q_count == DEPTH.

Behaviour:
- Reset (rst high at the edge):
  - gnt_n = all ones; gnt_valid = 0; gnt_idx = 0; q_count = 0; q_full = 0.
  - Queue pointers cleared; pending and queued flags cleared.
  - req_prev set to all ones, so a REQ# held low across reset is captured as a new request.
  - Applies mid-grant too: the grant drops at that edge and all queued entries are discarded.
- Request capture:
  - req_prev[i] registers req_n[i] every cycle.
  - A new request is req_n[i]==0 with req_prev[i]==1, and neither pending[i] nor queued[i] set.
  - A new request sets pending[i] at that edge.
- Enqueue:
  - At most one per cycle: the lowest-index pending device, when the queue is not full.
  - That device's pending bit clears and its queued bit sets.
  - If the queue is full, pending bits are held, never lost.
  - Each device occupies at most one entry.
- Withdrawal: if req_n[i] returns high while pending[i] is set, pending[i] clears.
- FSM states: IDLE, GRANT, GAP.
  - IDLE, queue non-empty, head's req_n low: go to GRANT. gnt_n[head] = 0, gnt_valid = 1, gnt_idx = head.
  - IDLE, queue non-empty, head's req_n high (stale entry): pop the head, clear its queued bit, stay in IDLE. No grant is issued.
  - GRANT: hold the grant until rel_i == 1 or the granted device's req_n == 1. Then pop the head, clear its queued bit, drive gnt_n to all ones, gnt_valid to 0, and go to GAP.
  - GAP: one cycle with no grant (turnaround), then go to IDLE.
- Latency: a falling REQ# is sampled at edge k, pending at k, enqueued at k+1, GNT# low after edge k+2 when the queue was empty and the FSM was in IDLE.
- Enqueue and pop in the same cycle: both occur; q_count is unchanged. This also applies when the queue is full.
- Pointers wrap modulo DEPTH; non-power-of-two DEPTH is supported.
- rel_i outside GRANT is ignored.
- At most one gnt_n bit is ever low.

Optional Feature:
- Macro: PCI_ARB_PARK_EN.
- Defined: in IDLE with the queue empty, gnt_n[PARK_DEV] = 0 while gnt_valid stays 0.
  - Parking is removed at the edge a grant is issued. The new grant appears directly if it is for PARK_DEV; otherwise the cycle before is all-ones.
  - Parking is not applied in GAP.
- Undefined: gnt_n is all ones whenever there is no queued grant.

Decomposition:
- Package pci_arb_pkg:
  - FSM state enum (IDLE/GRANT/GAP).
  - Function onehot_n(idx, n) returning the active-low one-hot vector; all-ones for an out-of-range or X index.
  - Index-width helper constant.
- Sub-module pci_arb_idx_fifo: circular buffer of IDX_W-bit entries.
  - Inputs: push, pop.
  - Outputs: head, count, full, empty.
  - Simultaneous push and pop are legal when full.

Test Plan:
- Single request: reset, then req_n = 8'hFB (device 2) at edge 5 -> gnt_n = 8'hFB after edge 7, gnt_idx = 2. rel_i at edge 10 -> gnt_n = 8'hFF after edge 10, GAP for one cycle.
- Ordering: device 5 falls at edge 3, device 1 at edge 4, device 6 at edge 5 -> grants issued in order 5, 1, 6, each separated by one all-ones cycle.
- Simultaneous requests: req_n = 8'h6F (devices 4 and 7) in one cycle -> enqueued as 4 then 7 on consecutive edges, q_count reaches 2.
- Full queue (DEPTH=2, N_DEV=8): devices 0, 1, 2 request -> q_full = 1 and device 2 stays pending. After the first pop, device 2 is enqueued in the same cycle, q_count stays 2, and device 2 is eventually granted.
- Withdrawal and mid-grant reset:
  - Device 3 queued behind device 0, then device 3's req_n goes high -> device 3 popped with no grant.
  - rst during a device 0 grant -> gnt_n = 8'hFF at the next edge, q_count = 0.
- PCI_ARB_PARK_EN, PARK_DEV = 0: idle bus -> gnt_n = 8'hFE with gnt_valid = 0. Device 4 request -> gnt_n goes 8'hFF for one cycle, then 8'hEF with gnt_valid = 1.
